dpwm_deadtime: RTL and testbench
================================

Name: dpwm_deadtime

Overview:
- Counter-comparator digital PWM. Consumes the 6-bit dithered duty word from the dither stage and drives the high-side and low-side gates of the synchronous buck power stage.
- Generates the switching-period strobe that advances the dither sequencer.
- Inserts programmable dead time on both gate transitions, so the two gates are never on together.

Parameters:
- N, 6: duty word and period counter width. Switching period = 2^N clk_in cycles.
- DT, 2: dead time in clk_in cycles. Legal range 1..7.
- DMAX, 60: maximum duty clamp. Legal range 0..2^N-1.

Ports:
- clk_in, input, 1: fast DPWM clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: converter run enable; synchronous.
- duty_in, input, N: dithered duty command. Must be stable in the cycle where cnt = 2^N-1.
- period_start, output, 1: high for the single cycle cnt = 0 while running. Clock/strobe for the dither sequencer.
- pwm_raw, output, 1: ungated PWM, before dead time.
- hs_gate, output, 1: high-side switch drive.
- ls_gate, output, 1: low-side switch drive.
- duty_lat, output, N: duty value in use for the current period.

Behaviour:
- Reset: cnt=0, duty_lat=0, state=OFF, dt_cnt=0. All outputs 0.
- Counter:
  - While en=1, cnt increments every cycle and wraps 2^N-1 -> 0.
  - While en=0, cnt is held at 0.
- Duty latch:
  - On the edge ending the cnt=2^N-1 cycle (en=1), duty_lat <= min(duty_in, DMAX).
  - No other updates while running. Mid-period changes to duty_in have no effect.
  - en=0 forces duty_lat=0.
- pwm_raw = en & (cnt < duty_lat), decoded from registers. High for cnt 0..duty_lat-1.
- period_start = en & (cnt==0), decoded from registers.
- Gate FSM:
  - States: OFF, LS_ON, DT_LH (dead before HS), HS_ON, DT_HL (dead before LS).
  - hs_gate = (state==HS_ON). ls_gate = (state==LS_ON). Both are registered decodes.
  - en=0 from any state -> OFF on the next edge; both gates low from the next cycle.
  - OFF & en -> LS_ON.
  - LS_ON & pwm_raw -> DT_LH, dt_cnt <= DT-1.
  - DT_LH: if !pwm_raw -> LS_ON (priority); else if dt_cnt==0 -> HS_ON; else dt_cnt--.
  - HS_ON & !pwm_raw -> DT_HL, dt_cnt <= DT-1.
  - DT_HL: if pwm_raw -> HS_ON (priority); else if dt_cnt==0 -> LS_ON; else dt_cnt--.
- Resulting timing per period (0 < D=duty_lat < 2^N):
  - hs_gate high for cnt DT+1..D, i.e. D-DT cycles.
  - ls_gate low for cnt 1..D+DT.
  - Pulses with D <= DT produce no hs pulse; ls dips low for cnt 1..D.
- D=0: ls_gate stays high for the whole period.
- Invariant: hs_gate & ls_gate never 1 in the same cycle, including under reset, en toggling and duty changes.
- Startup:
  - The first period after en rises has duty_lat=0, so it is a blank period with LS on from cycle 2.
  - The first commanded duty applies from the second period.
- rst asserted mid-operation: all state and outputs go to 0 immediately (asynchronous). Release behaves as from power-up.

Test Plan:
1. Startup and nominal duty (N=6, DT=2, duty_in=10, en=1 after reset):
   - period 0: hs=0, ls=1 from cnt 1.
   - from period 1: hs=1 for cnt 3..10 (8 cycles); ls=0 for cnt 1..12.
   - period_start every 64 cycles at cnt=0.
2. Short pulses:
   - duty_in=0: ls continuously 1, hs never 1.
   - duty_in=2: hs never 1; ls low only for cnt 1..2.
   - duty_in=3: hs high exactly 1 cycle, at cnt 3.
3. Clamp: duty_in=63 -> duty_lat=60; hs=1 for cnt 3..60; ls=1 from cnt 63 through cnt 0 of the next period.
4. Mid-period update: duty_in 10 -> 20 at cnt 30 -> current period keeps hs cnt 3..10; next period hs cnt 3..20; duty_lat changes on the cnt 63 -> 0 edge.
5. Enable drop: en=0 at cnt 5 while HS_ON -> next cycle hs=ls=0, cnt=0, duty_lat=0, period_start=0. Re-enable -> one blank period, then normal pulses.
6. Async rst pulse asserted at cnt 7 of an active period -> all outputs 0 before the next clk_in edge. A concurrent assertion checker confirms hs_gate & ls_gate==0 across scenarios 1-6.

Source files
------------

// File: rtl/dpwm_deadtime.sv
// rtl/dpwm_deadtime.sv - counter-comparator DPWM with dead-time gate sequencing
//
// Purpose: turns the dithered duty word into complementary high-side and
// low-side gate drives for a synchronous buck stage. The gates are kept
// non-overlapping, with DT clk_in cycles of dead time on each transition.
//
// Parameters:
//   N    - duty word / period counter width; period = 2^N clk_in cycles
//   DT   - dead time in clk_in cycles (1..7)
//   DMAX - maximum duty clamp (0..2^N-1)
//
// Ports:
//   clk_in       in   fast DPWM clock, rising edge
//   rst          in   asynchronous active-high reset
//   en           in   converter run enable (synchronous)
//   duty_in      in   [N-1:0] duty command, sampled in the cnt = 2^N-1 cycle
//   period_start out  high for the cnt = 0 cycle while running
//   pwm_raw      out  PWM before dead-time insertion
//   hs_gate      out  high-side switch drive
//   ls_gate      out  low-side switch drive
//   duty_lat     out  [N-1:0] duty value in use for the current period

module dpwm_deadtime #(
  parameter int N    = 6,
  parameter int DT   = 2,
  parameter int DMAX = 60
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] duty_in,
  output logic         period_start,
  output logic         pwm_raw,
  output logic         hs_gate,
  output logic         ls_gate,
  output logic [N-1:0] duty_lat
);

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] DMAX_W  = N'(DMAX);
  localparam logic [2:0]   DT_LOAD = 3'(DT - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_LS_ON,
    S_DT_LH,
    S_HS_ON,
    S_DT_HL
  } state_t;

  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] duty_lat_q, duty_lat_d;
  logic [2:0]   dt_cnt_q, dt_cnt_d;
  state_t       state_q, state_d;
  logic         hs_q, ls_q;

  // Period counter and duty latch. The duty word is captured only on the
  // edge that closes a period, so mid-period changes never alter a pulse.
  always_comb begin
    cnt_d      = cnt_q;
    duty_lat_d = duty_lat_q;
    if (!en) begin
      cnt_d      = '0;
      duty_lat_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_MAX) begin
        duty_lat_d = (duty_in > DMAX_W) ? DMAX_W : duty_in;
      end
    end
  end

  // Rst is folded into period_start because en may already be high while
  // reset is asserted; every other output is zero from the cleared registers.
  assign pwm_raw      = en & (cnt_q < duty_lat_q);
  assign period_start = en & ~rst & (cnt_q == '0);

  // Gate sequencer. A pwm_raw reversal during a dead-time interval returns
  // straight to the gate that was on, so a short pulse never turns on the
  // opposite switch.
  always_comb begin
    state_d  = state_q;
    dt_cnt_d = dt_cnt_q;
    if (!en) begin
      state_d  = S_OFF;
      dt_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_OFF: begin
          state_d = S_LS_ON;
        end
        S_LS_ON: begin
          if (pwm_raw) begin
            state_d  = S_DT_LH;
            dt_cnt_d = DT_LOAD;
          end
        end
        S_DT_LH: begin
          if (!pwm_raw) begin
            state_d = S_LS_ON;
          end else if (dt_cnt_q == '0) begin
            state_d = S_HS_ON;
          end else begin
            dt_cnt_d = dt_cnt_q - 1'b1;
          end
        end
        S_HS_ON: begin
          if (!pwm_raw) begin
            state_d  = S_DT_HL;
            dt_cnt_d = DT_LOAD;
          end
        end
        S_DT_HL: begin
          if (pwm_raw) begin
            state_d = S_HS_ON;
          end else if (dt_cnt_q == '0) begin
            state_d = S_LS_ON;
          end else begin
            dt_cnt_d = dt_cnt_q - 1'b1;
          end
        end
        default: begin
          state_d  = S_OFF;
          dt_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      duty_lat_q <= '0;
      dt_cnt_q   <= '0;
      state_q    <= S_OFF;
      hs_q       <= 1'b0;
      ls_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      duty_lat_q <= duty_lat_d;
      dt_cnt_q   <= dt_cnt_d;
      state_q    <= state_d;
      // Gate flops mirror the state register so the drives are glitch-free.
      hs_q       <= (state_d == S_HS_ON);
      ls_q       <= (state_d == S_LS_ON);
    end
  end

  assign hs_gate  = hs_q;
  assign ls_gate  = ls_q;
  assign duty_lat = duty_lat_q;

endmodule

// File: tb/tb_dpwm_deadtime.sv
// tb/tb_dpwm_deadtime.sv - directed self-checking bench for dpwm_deadtime

module tb_dpwm_deadtime;

  localparam int DT = 2;

  logic       clk_in;
  logic       rst;
  logic       en;
  logic [5:0] duty_in;
  logic       period_start;
  logic       pwm_raw;
  logic       hs_gate;
  logic       ls_gate;
  logic [5:0] duty_lat;

  int n_cmp = 0;
  int n_err = 0;
  int pnum  = 0;
  bit done  = 0;

  dpwm_deadtime #(.N(6), .DT(DT), .DMAX(60)) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .en           (en),
    .duty_in      (duty_in),
    .period_start (period_start),
    .pwm_raw      (pwm_raw),
    .hs_gate      (hs_gate),
    .ls_gate      (ls_gate),
    .duty_lat     (duty_lat)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // The gates must never overlap, whatever the scenario.
  always @(negedge clk_in) begin
    if (!done) check("overlap", {31'd0, hs_gate & ls_gate}, 32'd0);
  end

  // Drive one cycle's inputs just after the rising edge, then wait for the
  // falling edge where the outputs are sampled.
  task automatic tick(input logic en_v, input logic [5:0] duty_v);
    @(posedge clk_in);
    #1;
    en      = en_v;
    duty_in = duty_v;
    @(negedge clk_in);
  endtask

  task automatic chk_all_zero(input string tag);
    check({tag, " hs"}, {31'd0, hs_gate}, 32'd0);
    check({tag, " ls"}, {31'd0, ls_gate}, 32'd0);
    check({tag, " pwm"}, {31'd0, pwm_raw}, 32'd0);
    check({tag, " ps"}, {31'd0, period_start}, 32'd0);
    check({tag, " dl"}, {26'd0, duty_lat}, 32'd0);
  endtask

  // Expected outputs at counter value c for a running period with latched
  // duty d. A blank period is the first one after enable: the low side only
  // comes on from c=1.
  task automatic chk_cycle(input int c, input int d, input bit blank);
    int  ls_low_end;
    bit  e_hs, e_ls;
    string t;
    ls_low_end = (d <= DT) ? d : d + DT;
    e_hs = (d > DT) && (c >= DT + 1) && (c <= d);
    if (blank) e_ls = (c >= 1);
    else       e_ls = !((d > 0) && (c >= 1) && (c <= ls_low_end));
    t = $sformatf("p%0d c%0d", pnum, c);
    check({t, " ps"}, {31'd0, period_start}, {31'd0, c == 0});
    check({t, " pwm"}, {31'd0, pwm_raw}, {31'd0, c < d});
    check({t, " hs"}, {31'd0, hs_gate}, {31'd0, e_hs});
    check({t, " ls"}, {31'd0, ls_gate}, {31'd0, e_ls});
    check({t, " dl"}, {26'd0, duty_lat}, d);
  endtask

  // One full period; duty_in switches from da to db at counter value chg.
  task automatic run_period(input logic [5:0] da, input logic [5:0] db, input int chg,
                            input int d, input bit blank);
    for (int c = 0; c < 64; c++) begin
      tick(1'b1, (c < chg) ? da : db);
      chk_cycle(c, d, blank);
    end
    pnum++;
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    duty_in = 6'd0;
    repeat (2) @(negedge clk_in);
    chk_all_zero("reset");

    @(posedge clk_in);
    #1 rst = 1'b0;
    @(negedge clk_in);
    chk_all_zero("idle");

    // Startup, nominal duty, short pulses, clamp, mid-period update.
    run_period(6'd10, 6'd10, 64, 0,  1'b1);
    run_period(6'd10, 6'd10, 64, 10, 1'b0);
    run_period(6'd0,  6'd0,  64, 10, 1'b0);
    run_period(6'd2,  6'd2,  64, 0,  1'b0);
    run_period(6'd3,  6'd3,  64, 2,  1'b0);
    run_period(6'd63, 6'd63, 64, 3,  1'b0);
    run_period(6'd10, 6'd10, 64, 60, 1'b0);
    run_period(6'd10, 6'd20, 30, 10, 1'b0);
    run_period(6'd20, 6'd20, 64, 20, 1'b0);

    // Enable drop during cnt=5 while the high side is on.
    for (int c = 0; c < 5; c++) begin
      tick(1'b1, 6'd20);
      chk_cycle(c, 20, 1'b0);
    end
    tick(1'b0, 6'd20);
    check("drop c5 hs", {31'd0, hs_gate}, 32'd1);
    check("drop c5 ls", {31'd0, ls_gate}, 32'd0);
    check("drop c5 pwm", {31'd0, pwm_raw}, 32'd0);
    check("drop c5 dl", {26'd0, duty_lat}, 32'd20);
    tick(1'b0, 6'd20);
    chk_all_zero("drop+1");
    tick(1'b0, 6'd20);
    chk_all_zero("drop+2");
    pnum++;
    run_period(6'd20, 6'd20, 64, 0,  1'b1);
    run_period(6'd20, 6'd20, 64, 20, 1'b0);

    // Asynchronous reset pulse at cnt=7, well away from any clock edge.
    for (int c = 0; c < 8; c++) begin
      tick(1'b1, 6'd20);
      chk_cycle(c, 20, 1'b0);
    end
    #1 rst = 1'b1;
    #1 chk_all_zero("async rst");
    @(posedge clk_in);
    #1;
    rst = 1'b0;
    en  = 1'b0;
    @(negedge clk_in);
    chk_all_zero("rst release");
    pnum++;
    run_period(6'd20, 6'd20, 64, 0,  1'b1);
    run_period(6'd20, 6'd20, 64, 20, 1'b0);

    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
